bus_master_ctrl: RTL and testbench

BUS_MASTER_CTRL -- requirements
Module: bus_master_ctrl

---
 rtl/bus_pkg.sv | 25 ++
 rtl/bus_timeout_counter.sv | 31 +++
 rtl/bus_master_ctrl.sv | 165 ++++++++++++++++
 tb/tb_bus_master_ctrl.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/bus_pkg.sv
// Shared definitions for the bus master controller and its arbiter:
// FSM state encoding, default bus widths and arbiter bit indices.
package bus_pkg;

  localparam int DEF_ADDR_W = 14;
  localparam int DEF_DATA_W = 8;

  // Bit positions of UTIL and GRANT in the arbiter's per-master vectors.
  localparam int UTIL_BIT  = 0;
  localparam int GRANT_BIT = 1;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_REQ   = 3'd1,
    ST_ADDR  = 3'd2,
    ST_WAIT  = 3'd3,
    ST_SPLIT = 3'd4,
    ST_DONE  = 3'd5
  } state_t;

  function automatic int cnt_width(input int cyc);
    return $clog2(cyc) + 1;
  endfunction

endpackage

// File: rtl/bus_timeout_counter.sv
// WAIT-phase timeout counter: clears on demand, counts while enabled,
// saturates at TIMEOUT_CYC-1 and flags that terminal count.
module bus_timeout_counter
  import bus_pkg::*;
#(
  parameter int TIMEOUT_CYC = 64
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic terminal
);

  localparam int CNT_W = cnt_width(TIMEOUT_CYC);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYC - 1);

  logic [CNT_W-1:0] count;

  // Saturating: the FSM leaves WAIT on terminal count, but never wrap regardless.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count <= '0;
    end else if (enable && (count != LAST)) begin
      count <= count + CNT_W'(1);
    end
  end

  assign terminal = enable && (count == LAST);

endmodule

// File: rtl/bus_master_ctrl.sv
// Single-transaction bus master with request/grant arbitration, split
// support and an optional WAIT timeout (enabled by BUS_MASTER_CTRL_TIMEOUT_EN).
module bus_master_ctrl
  import bus_pkg::*;
#(
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int DATA_W      = DEF_DATA_W,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] addr_in,
  input  logic [DATA_W-1:0] wdata_in,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [DATA_W-1:0] rdata_out,
  output logic              bus_req,
  input  logic              bus_grant,
  output logic              bus_util,
  output logic              bus_valid,
  output logic              bus_rw,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_wdata,
  input  logic [DATA_W-1:0] bus_rdata,
  input  logic              slave_ready,
  input  logic              slave_split,
  output logic [2:0]        dbg_state
);

  // Handshake: start is honoured only in IDLE; slave_ready/slave_split are
  // sampled only in WAIT (ready has priority); bus_grant is sampled only in
  // REQ and SPLIT, so grant changes during ADDR/WAIT have no effect.

  state_t            state, state_next;
  logic              cmd_rw;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_wdata;
  logic [DATA_W-1:0] rdata_q;
  logic              timeout;
  logic              in_wait;

  assign in_wait   = (state == ST_WAIT);
  assign dbg_state = state;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:  if (start) state_next = ST_REQ;
      ST_REQ:   if (bus_grant) state_next = ST_ADDR;
      ST_ADDR:  state_next = ST_WAIT;
      ST_WAIT: begin
        if (slave_ready) begin
          state_next = ST_DONE;
        end else if (slave_split) begin
          state_next = ST_SPLIT;
        end else if (timeout) begin
          state_next = ST_IDLE;
        end
      end
      ST_SPLIT: if (bus_grant) state_next = ST_WAIT;
      ST_DONE:  state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    busy      = 1'b0;
    done      = 1'b0;
    bus_req   = 1'b0;
    bus_util  = 1'b0;
    bus_valid = 1'b0;
    case (state)
      ST_IDLE:  ;
      ST_REQ: begin
        busy    = 1'b1;
        bus_req = 1'b1;
      end
      ST_ADDR: begin
        busy      = 1'b1;
        bus_req   = 1'b1;
        bus_util  = 1'b1;
        bus_valid = 1'b1;
      end
      ST_WAIT: begin
        busy     = 1'b1;
        bus_req  = 1'b1;
        bus_util = 1'b1;
      end
      ST_SPLIT: busy = 1'b1;
      ST_DONE: begin
        busy = 1'b1;
        done = 1'b1;
      end
      default: ;
    endcase
    bus_rw    = bus_util ? cmd_rw    : 1'b0;
    bus_addr  = bus_util ? cmd_addr  : '0;
    bus_wdata = bus_util ? cmd_wdata : '0;
  end

  // Command is captured once per transaction; later starts cannot disturb it.
  always_ff @(posedge clk) begin
    if (reset) begin
      cmd_rw    <= 1'b0;
      cmd_addr  <= '0;
      cmd_wdata <= '0;
      rdata_q   <= '0;
    end else begin
      if ((state == ST_IDLE) && start) begin
        cmd_rw    <= wr_en;
        cmd_addr  <= addr_in;
        cmd_wdata <= wdata_in;
      end
      if (in_wait && slave_ready && !cmd_rw) begin
        rdata_q <= bus_rdata;
      end
    end
  end

  assign rdata_out = rdata_q;

`ifdef BUS_MASTER_CTRL_TIMEOUT_EN
  logic error_q;
  logic cnt_clear;

  assign cnt_clear = !in_wait;

  bus_timeout_counter #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_timeout (
    .clk      (clk),
    .reset    (reset),
    .clear    (cnt_clear),
    .enable   (in_wait),
    .terminal (timeout)
  );

  // Error is registered so its pulse lines up with the released bus in IDLE.
  always_ff @(posedge clk) begin
    if (reset) begin
      error_q <= 1'b0;
    end else begin
      error_q <= in_wait && !slave_ready && !slave_split && timeout;
    end
  end

  assign error = error_q;
`else
  localparam int unused_timeout_cyc = TIMEOUT_CYC;
  assign timeout = 1'b0;
  assign error   = 1'b0;
`endif

endmodule

// File: tb/tb_bus_master_ctrl.sv
// Randomized scoreboard bench for bus_master_ctrl; the bench acts as
// arbiter and slave and predicts every done/error completion.
module tb_bus_master_ctrl;

  localparam int ADDR_W = 14;
  localparam int DATA_W = 8;
  localparam int TCYC   = 8;

  logic              clk;
  logic              reset;
  logic              start;
  logic              wr_en;
  logic [ADDR_W-1:0] addr_in;
  logic [DATA_W-1:0] wdata_in;
  logic              busy;
  logic              done;
  logic              error;
  logic [DATA_W-1:0] rdata_out;
  logic              bus_req;
  logic              bus_grant;
  logic              bus_util;
  logic              bus_valid;
  logic              bus_rw;
  logic [ADDR_W-1:0] bus_addr;
  logic [DATA_W-1:0] bus_wdata;
  logic [DATA_W-1:0] bus_rdata;
  logic              slave_ready;
  logic              slave_split;
  logic [2:0]        dbg_state;

  bus_master_ctrl #(
    .ADDR_W      (ADDR_W),
    .DATA_W      (DATA_W),
    .TIMEOUT_CYC (TCYC)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .wr_en       (wr_en),
    .addr_in     (addr_in),
    .wdata_in    (wdata_in),
    .busy        (busy),
    .done        (done),
    .error       (error),
    .rdata_out   (rdata_out),
    .bus_req     (bus_req),
    .bus_grant   (bus_grant),
    .bus_util    (bus_util),
    .bus_valid   (bus_valid),
    .bus_rw      (bus_rw),
    .bus_addr    (bus_addr),
    .bus_wdata   (bus_wdata),
    .bus_rdata   (bus_rdata),
    .slave_ready (slave_ready),
    .slave_split (slave_split),
    .dbg_state   (dbg_state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  // Scoreboard: entries are {error_expected, rdata_out_expected}
  int                n_checks = 0;
  int                n_fail   = 0;
  logic [DATA_W:0]   exp_q[$];
  logic [DATA_W-1:0] rdata_model;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin : monitor
    logic [DATA_W:0] e;
    if (!reset && (done === 1'b1 || error === 1'b1)) begin
      check("done_xor_error", 32'(done ^ error), 32'd1);
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_completion: got done=%0b error=%0b expected none", done, error);
      end else begin
        e = exp_q.pop_front();
        check("completion", 32'({error, rdata_out}), 32'(e));
      end
    end
  end

  // Driver tasks
  task automatic issue(input logic wr, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] wd,
                       input int gdly, output bit ok);
    ok = 1'b0;
    @(negedge clk);
    start = 1'b1; wr_en = wr; addr_in = a; wdata_in = wd;
    @(negedge clk);
    start = 1'b0; wr_en = 1'($urandom); addr_in = ADDR_W'($urandom); wdata_in = DATA_W'($urandom);
    check("req_busy", 32'(busy), 32'd1);
    check("req_bus_req", 32'(bus_req), 32'd1);
    check("req_util", 32'(bus_util), 32'd0);
    repeat (gdly) @(negedge clk);
    bus_grant = 1'b1;
    for (int i = 0; i < 20 && bus_valid !== 1'b1; i++) @(negedge clk);
    if (bus_valid !== 1'b1) begin
      n_checks++; n_fail++;
      $display("FAIL addr_phase_timeout: got bus_valid=%0b expected 1 within 20 cycles", bus_valid);
      return;
    end
    ok = 1'b1;
    check("addr_bus_addr", 32'(bus_addr), 32'(a));
    check("addr_bus_wdata", 32'(bus_wdata), 32'(wd));
    check("addr_bus_rw", 32'(bus_rw), 32'(wr));
    check("addr_util_req", 32'({bus_util, bus_req}), 32'b11);
    bus_grant = 1'($urandom_range(0, 1));
    @(negedge clk);
    check("wait_valid_util", 32'({bus_valid, bus_util}), 32'b01);
  endtask

  task automatic run_txn(input logic wr, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] wd,
                         input int gdly, input int rdly, input bit do_split, input int sdly,
                         input logic [DATA_W-1:0] rd, input bit both, input bit poke, input int hold);
    bit ok;
    issue(wr, a, wd, gdly, ok);
    if (!ok) return;
    if (poke) begin
      start = 1'b1; wr_en = ~wr; addr_in = ~a;
      @(negedge clk);
      start = 1'b0;
    end
    if (do_split) begin
      repeat (sdly) @(negedge clk);
      slave_split = 1'b1;
      @(negedge clk);
      slave_split = 1'b0; bus_grant = 1'b0;
      check("split_util_req", 32'({bus_util, bus_req}), 32'b00);
      check("split_busy", 32'(busy), 32'd1);
      repeat (5) @(negedge clk);
      check("split_hold_util", 32'(bus_util), 32'd0);
      bus_grant = 1'b1;
      @(negedge clk);
      check("regrant_util", 32'(bus_util), 32'd1);
      check("regrant_addr", 32'(bus_addr), 32'(a));
      bus_grant = 1'($urandom_range(0, 1));
    end
    repeat (hold) @(negedge clk);
    if (hold > 0) check("long_wait_busy_util", 32'({busy, bus_util}), 32'b11);
    repeat (rdly) @(negedge clk);
    slave_ready = 1'b1; slave_split = both; bus_rdata = rd;
    if (!wr) rdata_model = rd;
    exp_q.push_back({1'b0, rdata_model});
    @(negedge clk);
    slave_ready = 1'b0; slave_split = 1'b0; bus_rdata = DATA_W'($urandom);
    check("done_bus_released", 32'({bus_util, bus_req}), 32'b00);
    @(negedge clk);
    bus_grant = 1'b0;
    check("idle_busy", 32'(busy), 32'd0);
    check("idle_done", 32'(done), 32'd0);
  endtask

`ifdef BUS_MASTER_CTRL_TIMEOUT_EN
  task automatic run_timeout(input logic wr, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] wd);
    bit ok;
    int n;
    issue(wr, a, wd, 1, ok);
    if (!ok) return;
    exp_q.push_back({1'b1, rdata_model});
    n = 0;
    while (error !== 1'b1 && n < TCYC + 4) begin
      @(negedge clk);
      n++;
    end
    check("timeout_latency", 32'(n), 32'(TCYC));
    check("timeout_released", 32'({busy, bus_util, bus_req, done}), 32'd0);
    bus_grant = 1'b0;
    @(negedge clk);
    check("timeout_error_pulse", 32'(error), 32'd0);
  endtask
`endif

  task automatic run_reset_mid_wait();
    bit ok;
    issue(1'b1, 14'h1555, 8'h5A, 0, ok);
    if (!ok) return;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("rst_ctrl_outputs", 32'({busy, done, error, bus_req, bus_util, bus_valid, bus_rw}), 32'd0);
    check("rst_bus_addr", 32'(bus_addr), 32'd0);
    check("rst_bus_wdata", 32'(bus_wdata), 32'd0);
    check("rst_rdata_out", 32'(rdata_out), 32'd0);
    reset = 1'b0; bus_grant = 1'b0; rdata_model = '0;
    repeat (2) @(negedge clk);
    check("post_rst_quiet", 32'({busy, done, error}), 32'd0);
  endtask

  // Stimulus
  initial begin
    reset = 1'b1; start = 1'b0; wr_en = 1'b0; addr_in = '0; wdata_in = '0;
    bus_grant = 1'b0; bus_rdata = '0; slave_ready = 1'b0; slave_split = 1'b0;
    rdata_model = '0;
    repeat (3) @(negedge clk);
    check("reset_ctrl_outputs", 32'({busy, done, error, bus_req, bus_util, bus_valid, bus_rw}), 32'd0);
    check("reset_bus_addr_wdata", 32'({bus_addr, bus_wdata}), 32'd0);
    check("reset_rdata_out", 32'(rdata_out), 32'd0);
    reset = 1'b0;
    @(negedge clk);

    run_txn(1'b1, 14'h0123, 8'hA5, 2, 2, 1'b0, 0, 8'h00, 1'b0, 1'b0, 0);
    run_txn(1'b0, 14'h0040, 8'h00, 0, 1, 1'b0, 0, 8'h3C, 1'b0, 1'b0, 0);
    run_txn(1'b1, 14'h0200, 8'h77, 1, 1, 1'b1, 1, 8'h00, 1'b0, 1'b0, 0);
    run_txn(1'b0, 14'h3FFF, 8'h11, 0, 0, 1'b0, 0, 8'hC3, 1'b1, 1'b1, 0);
`ifdef BUS_MASTER_CTRL_TIMEOUT_EN
    run_timeout(1'b0, 14'h0AAA, 8'h00);
    run_timeout(1'b1, 14'h0001, 8'hFF);
`else
    run_txn(1'b0, 14'h0AAA, 8'h00, 0, 0, 1'b0, 0, 8'h96, 1'b0, 1'b0, 3 * TCYC);
`endif
    run_txn(1'b0, 14'h0100, 8'h00, 0, 2, 1'b0, 0, 8'h81, 1'b0, 1'b0, 0);
    run_reset_mid_wait();

    for (int i = 0; i < 30; i++) begin
      run_txn(1'($urandom), ADDR_W'($urandom), DATA_W'($urandom),
              $urandom_range(0, 4), $urandom_range(0, 5),
              ($urandom_range(0, 3) == 0), $urandom_range(0, 3),
              DATA_W'($urandom), 1'($urandom), ($urandom_range(0, 4) == 0), 0);
    end

    repeat (5) @(negedge clk);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
